// File: rtl/mem_cell_master.sv
// mem_cell_master: request/response controller that sequences writes, reads and
// mode-switch resets into mem_cell, guarding against overflow and underflow.
module mem_cell_master #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_mode,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [7:0]       err_count,
    output logic [31:0]      mem_din,
    output logic [2:0]       mem_mode,
    output logic [2:0]       mem_chip_en,
    output logic [1:0]       mem_rw,
    output logic             mem_reset,
    input  logic [31:0]      mem_dout,
    input  logic             mem_full,
    input  logic             mem_empty
);
    typedef enum logic [2:0] {IDLE, SW_RST, SW_WAIT, WRITE, READ, RD_WAIT, RESP} state_t;
    state_t           r_state, w_next;
    logic             r_write;
    logic [2:0]       r_mode, r_cur_mode;
    logic [WIDTH-1:0] r_data, r_rsp_data;
    logic [31:0]      r_din;
    logic [1:0]       r_lat;
    logic             r_rsp_err;
    logic [7:0]       r_err_count;
    logic             w_accept, w_legal, w_lat_done, w_unused;

    assign w_accept   = req_valid && req_ready;
    assign w_legal    = req_mode == 3'b001 || req_mode == 3'b010 || req_mode == 3'b100;
    assign w_lat_done = r_lat == 2'(RD_LAT - 1);
    // Only the low WIDTH bits of the memory word form a response.
    assign w_unused   = ^mem_dout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_mode      <= '0;
            r_cur_mode  <= '0;
            r_data      <= '0;
            r_din       <= '0;
            r_lat       <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next;
            r_din   <= mem_din;
            r_lat   <= r_state == RD_WAIT ? r_lat + 2'd1 : 2'd0;
            if (w_accept) begin
                r_write <= req_write;
                r_mode  <= req_mode;
                r_data  <= req_data;
            end
            if (r_state == SW_RST)
                r_cur_mode <= r_mode;
            if (w_accept && !w_legal) begin
                r_rsp_err  <= 1'b1;
                r_rsp_data <= '0;
            end
            if (r_state == WRITE || r_state == READ) begin
                r_rsp_err  <= r_state == WRITE ? mem_full : mem_empty;
                r_rsp_data <= '0;
            end
            if (r_state == RD_WAIT && w_lat_done)
                r_rsp_data <= mem_dout[WIDTH-1:0];
            if (rsp_valid && rsp_ready && r_rsp_err && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = !w_legal ? RESP : req_mode != r_cur_mode ? SW_RST : req_write ? WRITE : READ;
            SW_RST:  w_next = SW_WAIT;
            SW_WAIT: w_next = r_write ? WRITE : READ;
            WRITE:   w_next = RESP;
            READ:    w_next = mem_empty ? RESP : RD_WAIT;
            RD_WAIT: if (w_lat_done) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = r_state == IDLE && reset;
        rsp_valid   = r_state == RESP;
        rsp_data    = r_rsp_data;
        rsp_err     = r_rsp_err;
        err_count   = r_err_count;
        mem_reset   = r_state == SW_RST;
        mem_rw      = r_state == WRITE && !mem_full ? 2'd1 : r_state == READ && !mem_empty ? 2'd2 : 2'd0;
        mem_din     = mem_rw == 2'd1 ? 32'(r_data) : r_din;
        mem_mode    = r_cur_mode;
        mem_chip_en = r_cur_mode;
    end
endmodule

// File: tb/tb_mem_cell_master.sv
// tb_mem_cell_master: drives requests against a behavioural mem_cell and checks
// every response against a request-level reference model.
module tb_mem_cell_master;
    localparam int WIDTH = 8, RD_LAT = 2, DEPTH = 8;

    logic             clk = 0, reset = 0;
    logic             req_valid = 0, req_ready, req_write = 0, rsp_valid, rsp_ready = 0, rsp_err;
    logic [2:0]       req_mode = 0, mem_mode, mem_chip_en;
    logic [WIDTH-1:0] req_data = 0, rsp_data;
    logic [7:0]       err_count;
    logic [31:0]      mem_din, mem_dout;
    logic [1:0]       mem_rw;
    logic             mem_reset, mem_full, mem_empty;
    int               n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_cell_master #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_mode(req_mode), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .err_count(err_count), .mem_din(mem_din),
        .mem_mode(mem_mode), .mem_chip_en(mem_chip_en), .mem_rw(mem_rw),
        .mem_reset(mem_reset), .mem_dout(mem_dout), .mem_full(mem_full),
        .mem_empty(mem_empty)
    );

    // Behavioural mem_cell: bounded queue, LIFO pops from the back, Dout delayed RD_LAT cycles.
    logic [31:0] mq[$];
    logic [31:0] dpipe[RD_LAT] = '{default: 0};
    logic        model_full = 0, model_empty = 1, force_full = 0;
    assign mem_full  = model_full | force_full;
    assign mem_empty = model_empty;
    assign mem_dout  = dpipe[RD_LAT-1];

    always @(posedge clk) begin
        logic [31:0] v;
        v = dpipe[0];
        if (mem_reset) mq.delete();
        else if (mem_rw == 2'd1 && mq.size() < DEPTH) mq.push_back(mem_din);
        else if (mem_rw == 2'd2 && mq.size() > 0) v = mem_mode == 3'b100 ? mq.pop_back() : mq.pop_front();
        dpipe[0] <= v;
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
        model_full  <= mq.size() == DEPTH;
        model_empty <= mq.size() == 0;
    end

    // Request-level reference: what each request should return and how long it should take.
    logic [2:0]       ref_mode = 0;
    logic [WIDTH-1:0] ref_q[$];
    int               ref_errs = 0;

    function automatic void ref_predict(input logic w, input logic [2:0] m, input logic [WIDTH-1:0] d,
                                        output logic e, output logic [WIDTH-1:0] rd, output int lat, output int nrst);
        e = 0; rd = 0; lat = 1; nrst = 0;
        if (!(m inside {3'b001, 3'b010, 3'b100})) begin
            e = 1; lat = 0;
        end else begin
            if (m != ref_mode) begin
                ref_q.delete(); ref_mode = m; lat = 3; nrst = 1;
            end
            if (w) begin
                if (ref_q.size() == DEPTH || force_full) e = 1;
                else ref_q.push_back(d);
            end else if (ref_q.size() == 0) e = 1;
            else begin
                rd = m == 3'b100 ? ref_q.pop_back() : ref_q.pop_front();
                lat += RD_LAT;
            end
        end
        if (e && ref_errs < 255) ref_errs++;
    endfunction

    // Issue one request at a negedge, observe it to completion, consume the response after `hold` stalled cycles.
    task automatic do_req(input logic w, input logic [2:0] m, input logic [WIDTH-1:0] d, input int hold,
                          output logic e, output logic [WIDTH-1:0] rd, output int lat, output int nrst,
                          output int nrw, output bit stable, output bit ok);
        int c = 0;
        e = 0; rd = 0; lat = 0; nrst = 0; nrw = 0; stable = 1;
        req_valid = 1; req_write = w; req_mode = m; req_data = d;
        while (!req_ready && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        req_valid = 0;
        while (!rsp_valid && lat < 20) begin
            if (mem_reset) nrst++;
            if (mem_rw != 0) nrw++;
            if (mem_reset && mem_rw != 0) stable = 0;
            @(negedge clk);
            lat++;
        end
        ok = rsp_valid && c < 20;
        e = rsp_err; rd = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_err !== e || rsp_data !== rd || req_ready) stable = 0;
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        #1;
        n_tests++;
        if (req_ready !== 0 || rsp_valid !== 0 || rsp_err !== 0 || rsp_data !== 0 || err_count !== 0 ||
            mem_din !== 0 || mem_mode !== 0 || mem_chip_en !== 0 || mem_rw !== 0 || mem_reset !== 0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b valid=%b err=%b data=%h cnt=%0d din=%h mode=%b ce=%b rw=%0d mrst=%b, all required 0",
                     req_ready, rsp_valid, rsp_err, rsp_data, err_count, mem_din, mem_mode, mem_chip_en, mem_rw, mem_reset);
        end
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1) begin n_fail++; $display("FAIL reset_release_ready: got %b need 1", req_ready); end
    endtask

    task automatic test_ordering(input logic [2:0] m);
        logic e, ee; logic [WIDTH-1:0] rd, erd; int lat, elat, nrst, enrst, nrw; bit st, ok;
        for (int i = 1; i <= 3; i++) begin
            ref_predict(1, m, WIDTH'(i), ee, erd, elat, enrst);
            do_req(1, m, WIDTH'(i), 0, e, rd, lat, nrst, nrw, st, ok);
            n_tests++;
            if (!ok || !st || e !== ee || lat != elat || nrst != enrst || nrw != 1 || mem_mode !== m || mem_chip_en !== m) begin
                n_fail++;
                $display("FAIL order_wr mode=%b #%0d: ok=%0d st=%0d err=%b/%b lat=%0d/%0d mrst=%0d/%0d rw=%0d/1 mode=%b ce=%b",
                         m, i, ok, st, e, ee, lat, elat, nrst, enrst, nrw, mem_mode, mem_chip_en);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            ref_predict(0, m, 0, ee, erd, elat, enrst);
            do_req(0, m, 0, 0, e, rd, lat, nrst, nrw, st, ok);
            n_tests++;
            if (!ok || e !== ee || rd !== erd || lat != elat || lat != RD_LAT + 1 || nrst != 0 || nrw != 1) begin
                n_fail++;
                $display("FAIL order_rd mode=%b #%0d: ok=%0d err=%b/%b data=%h/%h lat=%0d/%0d mrst=%0d rw=%0d",
                         m, i, ok, e, ee, rd, erd, lat, elat, nrst, nrw);
            end
        end
    endtask

    task automatic test_empty();
        logic e, ee; logic [WIDTH-1:0] rd, erd; int lat, elat, nrst, enrst, nrw; bit st, ok;
        ref_predict(0, 3'b001, 0, ee, erd, elat, enrst);
        do_req(0, 3'b001, 0, 0, e, rd, lat, nrst, nrw, st, ok);
        n_tests++;
        if (!ok || e !== 1 || rd !== 0 || nrw != 0 || nrst != 1 || lat != elat || err_count !== 8'(ref_errs)) begin
            n_fail++;
            $display("FAIL empty_guard: ok=%0d err=%b/1 data=%h/0 rw=%0d/0 mrst=%0d/1 lat=%0d/%0d cnt=%0d/%0d",
                     ok, e, rd, nrw, nrst, lat, elat, err_count, ref_errs);
        end
    endtask

    task automatic test_full_illegal();
        logic e, ee; logic [WIDTH-1:0] rd, erd; int lat, elat, nrst, enrst, nrw; bit st, ok;
        force_full = 1;
        ref_predict(1, 3'b001, 5, ee, erd, elat, enrst);
        do_req(1, 3'b001, 5, 0, e, rd, lat, nrst, nrw, st, ok);
        force_full = 0;
        n_tests++;
        if (!ok || e !== 1 || rd !== 0 || nrw != 0 || lat != elat) begin
            n_fail++;
            $display("FAIL full_guard: ok=%0d err=%b/1 data=%h/0 rw=%0d/0 lat=%0d/%0d", ok, e, rd, nrw, lat, elat);
        end
        ref_predict(1, 3'b011, 7, ee, erd, elat, enrst);
        do_req(1, 3'b011, 7, 0, e, rd, lat, nrst, nrw, st, ok);
        n_tests++;
        if (!ok || e !== 1 || rd !== 0 || nrst != 0 || nrw != 0 || lat != 0 || mem_mode !== 3'b001 || err_count !== 8'(ref_errs)) begin
            n_fail++;
            $display("FAIL illegal_mode: ok=%0d err=%b/1 data=%h/0 mrst=%0d/0 rw=%0d/0 lat=%0d/0 mode=%b/001 cnt=%0d/%0d",
                     ok, e, rd, nrst, nrw, lat, mem_mode, err_count, ref_errs);
        end
    endtask

    task automatic test_backpressure();
        logic e, ee; logic [WIDTH-1:0] rd, erd; int lat, elat, nrst, enrst, nrw; bit st, ok;
        ref_predict(1, 3'b001, 8'h2A, ee, erd, elat, enrst);
        do_req(1, 3'b001, 8'h2A, 0, e, rd, lat, nrst, nrw, st, ok);
        ref_predict(0, 3'b001, 0, ee, erd, elat, enrst);
        do_req(0, 3'b001, 0, 5, e, rd, lat, nrst, nrw, st, ok);
        n_tests++;
        if (!ok || !st || e !== 0 || rd !== 8'h2A || erd !== 8'h2A || req_ready !== 1 || rsp_valid !== 0) begin
            n_fail++;
            $display("FAIL backpressure: ok=%0d stable=%0d err=%b/0 data=%h/2a ready=%b/1 valid=%b/0",
                     ok, st, e, rd, req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        logic e, ee; logic [WIDTH-1:0] rd, erd; int lat, elat, nrst, enrst, nrw, seen = 0; bit st, ok;
        ref_predict(1, 3'b001, 8'h55, ee, erd, elat, enrst);
        do_req(1, 3'b001, 8'h55, 0, e, rd, lat, nrst, nrw, st, ok);
        req_valid = 1; req_write = 0; req_mode = 3'b001;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        reset = 0;
        #1;
        n_tests++;
        if (req_ready !== 0 || rsp_valid !== 0 || rsp_data !== 0 || err_count !== 0 || mem_mode !== 0 || mem_chip_en !== 0 ||
            mem_rw !== 0 || mem_reset !== 0 || mem_din !== 0) begin
            n_fail++;
            $display("FAIL mid_read_reset: ready=%b valid=%b data=%h cnt=%0d mode=%b ce=%b rw=%0d mrst=%b din=%h, all required 0",
                     req_ready, rsp_valid, rsp_data, err_count, mem_mode, mem_chip_en, mem_rw, mem_reset, mem_din);
        end
        ref_q.delete(); ref_mode = 0; ref_errs = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsp_valid) seen++; end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL mid_read_no_rsp: rsp_valid seen %0d cycles, required 0", seen); end
        ref_predict(1, 3'b001, 8'h11, ee, erd, elat, enrst);
        do_req(1, 3'b001, 8'h11, 0, e, rd, lat, nrst, nrw, st, ok);
        n_tests++;
        if (!ok || nrst != 1 || lat != 3 || e !== 0) begin
            n_fail++;
            $display("FAIL post_reset_switch: ok=%0d mrst=%0d/1 lat=%0d/3 err=%b/0", ok, nrst, lat, e);
        end
    endtask

    task automatic test_random();
        logic e, ee, w; logic [WIDTH-1:0] rd, erd, d; logic [2:0] m, cm = 3'b010;
        int lat, elat, nrst, enrst, nrw, hold; bit st, ok;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) m = 3'($urandom_range(0, 7));
            else m = cm;
            if (m inside {3'b001, 3'b010, 3'b100}) cm = m;
            w = 1'($urandom_range(0, 4) < 3);
            d = WIDTH'($urandom);
            hold = $urandom_range(0, 2);
            ref_predict(w, m, d, ee, erd, elat, enrst);
            do_req(w, m, d, hold, e, rd, lat, nrst, nrw, st, ok);
            n_tests++;
            if (!ok || !st || e !== ee || rd !== erd || lat != elat || nrst != enrst || nrw != (ee ? 0 : 1) ||
                mem_chip_en !== mem_mode || err_count !== 8'(ref_errs)) begin
                n_fail++;
                $display("FAIL random #%0d w=%b mode=%b: ok=%0d st=%0d err=%b/%b data=%h/%h lat=%0d/%0d mrst=%0d/%0d rw=%0d ce=%b mode=%b cnt=%0d/%0d",
                         k, w, m, ok, st, e, ee, rd, erd, lat, elat, nrst, enrst, nrw, mem_chip_en, mem_mode, err_count, ref_errs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordering(3'b010);
        test_ordering(3'b100);
        test_empty();
        test_full_illegal();
        test_backpressure();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
